// File: rtl/lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_gen : seedable Fibonacci XNOR LFSR with valid/ready output and period  |
// | done flag. Rev 1.0                                                          |
// +----------------------------------------------------------------------------+
module lfsr_gen #(
  parameter int NUM_BITS = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic                i_Enable,
  input  logic                i_Ready,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Valid,
  output logic                o_LFSR_Done,
  output logic [NUM_BITS-1:0] o_Step_Count,
  output logic                o_Seed_Err
);

  // Maximal-length tap masks (XAPP052), bit t-1 set for tap t.
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:       tap_mask = 32'h0000_0006;
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]         c_taps32 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] c_taps   = c_taps32[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] c_last   = {{(NUM_BITS-1){1'b1}}, 1'b0};
  localparam logic [NUM_BITS-1:0] c_one    = {{(NUM_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_BITS-1:0] r_lfsr;
  logic [NUM_BITS-1:0] r_seed;
  logic [NUM_BITS-1:0] r_count;
  logic                r_valid;
  logic                r_done;
  logic                r_seed_err;

  logic                w_fb;
  logic [NUM_BITS-1:0] w_lfsr_step;
  logic                w_seed_bad;
  logic [NUM_BITS-1:0] w_seed_val;
  logic                w_handshake;
  logic                w_wrap;

  // All-ones is the XNOR lock-up state, so such a seed is replaced by zero.
  assign w_fb        = ~^(r_lfsr & c_taps);
  assign w_lfsr_step = {r_lfsr[NUM_BITS-2:0], w_fb};
  assign w_seed_bad  = &i_Seed_Data;
  assign w_seed_val  = w_seed_bad ? '0 : i_Seed_Data;
  assign w_handshake = (r_state == RUN) && i_Enable && i_Ready && !i_Seed_DV;
  assign w_wrap      = w_handshake && (r_count == c_last);

  always_comb begin
    w_state_next = r_state;
    if (i_Seed_DV) begin
      w_state_next = LOAD;
    end else begin
      case (r_state)
        IDLE:    if (i_Enable) w_state_next = RUN;
        LOAD:    w_state_next = i_Enable ? RUN : IDLE;
        RUN:     if (!i_Enable) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_lfsr     <= '0;
      r_seed     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_valid    <= (w_state_next == RUN);
      r_done     <= w_wrap && (w_lfsr_step == r_seed);
      // Gated by its own previous value so back-to-back bad loads stay a pulse.
      r_seed_err <= i_Seed_DV && w_seed_bad && !r_seed_err;
      if (i_Seed_DV) begin
        r_lfsr  <= w_seed_val;
        r_seed  <= w_seed_val;
        r_count <= '0;
      end else if (w_handshake) begin
        r_lfsr  <= w_lfsr_step;
        r_count <= w_wrap ? '0 : r_count + c_one;
      end
    end
  end

  assign o_LFSR_Data  = r_lfsr;
  assign o_LFSR_Valid = r_valid;
  assign o_LFSR_Done  = r_done;
  assign o_Step_Count = r_count;
  assign o_Seed_Err   = r_seed_err;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lfsr_gen : self-checking bench for lfsr_gen at widths 3, 4 and 8.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_lfsr_gen;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;

  logic       clk = 1'b0;
  logic       rst, dv, en, rdy;
  logic [7:0] sd;

  logic [2:0] d3, c3;
  logic [3:0] d4, c4;
  logic [7:0] d8, c8;
  logic       v3, v4, v8, dn3, dn4, dn8, e3, e4, e8;

  int n_checks = 0;
  int n_fail   = 0;

  int W[3]     = '{3, 4, 8};
  int tbl3[8]  = '{0, 1, 3, 6, 5, 2, 4, 0};
  int m_st[3], m_d[3], m_c[3], m_v[3], m_dn[3], m_e[3];

  always #5 clk = ~clk;

  lfsr_gen #(.NUM_BITS(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_Seed_DV(dv), .i_Seed_Data(sd[2:0]),
    .i_Enable(en), .i_Ready(rdy), .o_LFSR_Data(d3), .o_LFSR_Valid(v3),
    .o_LFSR_Done(dn3), .o_Step_Count(c3), .o_Seed_Err(e3));

  lfsr_gen #(.NUM_BITS(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Seed_DV(dv), .i_Seed_Data(sd[3:0]),
    .i_Enable(en), .i_Ready(rdy), .o_LFSR_Data(d4), .o_LFSR_Valid(v4),
    .o_LFSR_Done(dn4), .o_Step_Count(c4), .o_Seed_Err(e4));

  lfsr_gen #(.NUM_BITS(8)) dut8 (
    .i_Clk(clk), .i_Rst(rst), .i_Seed_DV(dv), .i_Seed_Data(sd),
    .i_Enable(en), .i_Ready(rdy), .o_LFSR_Data(d8), .o_LFSR_Valid(v8),
    .o_LFSR_Done(dn8), .o_Step_Count(c8), .o_Seed_Err(e8));

  // Next LFSR value from the tap list: shift left, insert XNOR of the taps.
  function automatic int lfsr_next(input int w, input int d);
    int tm;
    case (w)
      3:       tm = (1 << 2) | (1 << 1);
      4:       tm = (1 << 3) | (1 << 2);
      default: tm = (1 << 7) | (1 << 5) | (1 << 4) | (1 << 3);
    endcase
    return ((d << 1) | ((($countones(d & tm) % 2) == 0) ? 1 : 0)) & ((1 << w) - 1);
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int ones;
      int s;
      ones = (1 << W[k]) - 1;
      if (rst) begin
        m_st[k] = S_IDLE; m_d[k] = 0; m_c[k] = 0; m_v[k] = 0; m_dn[k] = 0; m_e[k] = 0;
      end else if (dv) begin
        s       = int'(sd) & ones;
        m_e[k]  = (s == ones && m_e[k] == 0) ? 1 : 0;
        m_d[k]  = (s == ones) ? 0 : s;
        m_c[k]  = 0;
        m_dn[k] = 0;
        m_st[k] = S_LOAD;
        m_v[k]  = 0;
      end else begin
        m_e[k]  = 0;
        m_dn[k] = 0;
        if (m_st[k] == S_RUN && en && rdy) begin
          m_d[k] = lfsr_next(W[k], m_d[k]);
          if (m_c[k] == ones - 1) begin
            m_c[k]  = 0;
            m_dn[k] = 1;
          end else begin
            m_c[k] = m_c[k] + 1;
          end
        end
        m_st[k] = en ? S_RUN : S_IDLE;
        m_v[k]  = (m_st[k] == S_RUN) ? 1 : 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dv = 1'b0; en = 1'b0; rdy = 1'b0; sd = 8'h00;
    tick();
    tick();
    n_checks++;
    if ({d3, c3, v3, dn3, e3} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_n3: data=%h count=%h valid=%b done=%b err=%b, expected all 0", d3, c3, v3, dn3, e3);
    end
    n_checks++;
    if ({d4, c4, v4, dn4, e4} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_n4: data=%h count=%h valid=%b done=%b err=%b, expected all 0", d4, c4, v4, dn4, e4);
    end
    n_checks++;
    if ({d8, c8, v8, dn8, e8} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_n8: data=%h count=%h valid=%b done=%b err=%b, expected all 0", d8, c8, v8, dn8, e8);
    end
    rst = 1'b0;
  endtask

  task automatic test_period3();
    en = 1'b1; rdy = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (d3 !== 3'(tbl3[k]) || c3 !== 3'(k % 7) || dn3 !== (k == 7) || v3 !== 1'b1) begin
        n_fail++;
        $display("FAIL period3 step %0d: data=%0d count=%0d done=%b valid=%b, expected data=%0d count=%0d done=%b valid=1",
                 k, d3, c3, dn3, v3, tbl3[k], k % 7, (k == 7));
      end
    end
    tick();
    n_checks++;
    if (dn3 !== 1'b0 || d3 !== 3'd1) begin
      n_fail++;
      $display("FAIL period3_after_done: done=%b data=%0d, expected done=0 data=1", dn3, d3);
    end
  endtask

  task automatic test_ready_toggle();
    int pat[4] = '{1, 0, 0, 1};
    int idx = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; rdy = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      rdy = pat[i % 4][0];
      tick();
      if (pat[i % 4] == 1) idx++;
      n_checks++;
      if (d3 !== 3'(tbl3[idx % 7]) || c3 !== 3'(idx % 7) || v3 !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_toggle cycle %0d: data=%0d count=%0d valid=%b, expected data=%0d count=%0d valid=1",
                 i, d3, c3, v3, tbl3[idx % 7], idx % 7);
      end
    end
  endtask

  task automatic test_bad_seed();
    bit seen[16];
    int distinct = 0;
    bit got_done = 1'b0;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    en = 1'b0; rdy = 1'b1; dv = 1'b1; sd = 8'hFF;
    tick();
    dv = 1'b0;
    n_checks++;
    if (e4 !== 1'b1 || d4 !== 4'h0 || v4 !== 1'b0 || c4 !== 4'h0 || e8 !== 1'b1 || d8 !== 8'h00) begin
      n_fail++;
      $display("FAIL bad_seed_load: err4=%b data4=%h valid4=%b count4=%h err8=%b data8=%h, expected 1,0,0,0,1,00",
               e4, d4, v4, c4, e8, d8);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (e4 !== 1'b0 || v4 !== 1'b1 || d4 !== 4'h0) begin
      n_fail++;
      $display("FAIL bad_seed_pulse: err4=%b valid4=%b data4=%h, expected err=0 valid=1 data=0", e4, v4, d4);
    end
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (dn4) begin
        got_done = 1'b1;
      end else begin
        if (!seen[d4]) begin
          seen[d4] = 1'b1;
          distinct++;
        end
        tick();
      end
    end
    n_checks++;
    if (!got_done || distinct != 15 || seen[15] || d4 !== 4'h0) begin
      n_fail++;
      $display("FAIL bad_seed_period4: done_seen=%b distinct=%0d ones_seen=%b data_at_done=%h, expected 1,15,0,0",
               got_done, distinct, seen[15], d4);
    end
  endtask

  task automatic test_seed8();
    int ndone = 0;
    dv = 1'b1; sd = 8'h5A; en = 1'b1; rdy = 1'b1;
    tick();
    dv = 1'b0;
    n_checks++;
    if (d8 !== 8'h5A || v8 !== 1'b0 || c8 !== 8'h00 || e8 !== 1'b0) begin
      n_fail++;
      $display("FAIL seed8_load: data=%h valid=%b count=%h err=%b, expected 5a,0,00,0", d8, v8, c8, e8);
    end
    tick();
    n_checks++;
    if (d8 !== 8'h5A || v8 !== 1'b1) begin
      n_fail++;
      $display("FAIL seed8_single_invalid: data=%h valid=%b, expected 5a,1", d8, v8);
    end
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (dn8) ndone++;
    end
    n_checks++;
    if (d8 !== 8'h5A || dn8 !== 1'b1 || c8 !== 8'h00 || ndone != 1) begin
      n_fail++;
      $display("FAIL seed8_period: data=%h done=%b count=%h done_pulses=%0d, expected 5a,1,00,1", d8, dn8, c8, ndone);
    end
    tick();
    n_checks++;
    if (dn8 !== 1'b0) begin
      n_fail++;
      $display("FAIL seed8_done_width: done=%b, expected 0", dn8);
    end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; rdy = 1'b1;
    tick();
    tick(); tick(); tick();
    n_checks++;
    if (c3 !== 3'd3 || c8 !== 8'd3) begin
      n_fail++;
      $display("FAIL midrun_count: count3=%0d count8=%0d, expected 3,3", c3, c8);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (d8 !== 8'h00 || c8 !== 8'h00 || v8 !== 1'b0 || dn8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: data=%h count=%h valid=%b done=%b, expected 00,00,0,0", d8, c8, v8, dn8);
    end
    tick();
    n_checks++;
    if (d8 !== 8'h00 || c8 !== 8'h00 || v8 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_idle_exit: data=%h count=%h valid=%b, expected 00,00,1", d8, c8, v8);
    end
  endtask

  task automatic test_collision();
    logic [7:0] s;
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    s  = 8'($urandom_range(0, 254));
    dv = 1'b1; sd = s;
    tick();
    dv = 1'b0;
    n_checks++;
    if (d8 !== s || c8 !== 8'h00 || v8 !== 1'b0 || dn8 !== 1'b0) begin
      n_fail++;
      $display("FAIL collision: data=%h count=%h valid=%b done=%b, expected %h,00,0,0", d8, c8, v8, dn8, s);
    end
  endtask

  task automatic test_random();
    integer ad[3], ac[3], av[3], adn[3], ae[3];
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      dv  = ($urandom_range(0, 11) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      rdy = 1'($urandom_range(0, 1));
      tick();
      ad[0] = d3;  ad[1] = d4;  ad[2] = d8;
      ac[0] = c3;  ac[1] = c4;  ac[2] = c8;
      av[0] = v3;  av[1] = v4;  av[2] = v8;
      adn[0] = dn3; adn[1] = dn4; adn[2] = dn8;
      ae[0] = e3;  ae[1] = e4;  ae[2] = e8;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (ad[k] !== m_d[k] || ac[k] !== m_c[k] || av[k] !== m_v[k] || adn[k] !== m_dn[k] ||
            ae[k] !== m_e[k] || ad[k] === (1 << W[k]) - 1) begin
          n_fail++;
          $display("FAIL random cyc %0d N=%0d: data=%0h count=%0d valid=%0d done=%0d err=%0d, expected %0h,%0d,%0d,%0d,%0d",
                   i, W[k], ad[k], ac[k], av[k], adn[k], ae[k], m_d[k], m_c[k], m_v[k], m_dn[k], m_e[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_period3();
    test_ready_toggle();
    test_bad_seed();
    test_seed8();
    test_reset_midrun();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion before 500000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
